tilt_step_sched: RTL and testbench
==================================

TILT_STEP_SCHED -- requirements
Module: tilt_step_sched

Interface
- REQ-001 Parameter TICK_DIV, default 100000: clk cycles per scheduler tick (1 ms at 100 MHz); SHALL be forced to 4 when SIMULATE=1.
- REQ-002 Parameter SIMULATE, default 0: 1 selects the short simulation tick.
- REQ-003 Parameter DEADZONE, default 16: magnitude at or below which an axis produces no steps.
- REQ-004 Parameter PERIOD_MAX, default 255; parameter PERIOD_MIN, default 8: step period bounds, in ticks.
- REQ-005 Port clk, input, 1: system clock; the block SHALL use one clock; all logic SHALL be on its rising edge.
- REQ-006 Port reset, input, 1: asynchronous, active-high reset.
- REQ-007 Ports accel_x and accel_y, input, 9 each: two's-complement tilt samples from the accelerometer controller.
- REQ-008 Port accel_valid, input, 1: one-cycle strobe; both samples are valid in that cycle.
- REQ-009 Port enable, input, 1: scheduler run enable.
- REQ-010 Port step_valid, output, 1: a ball move request is offered.
- REQ-011 Port step_axis, output, 1: 0 = X, 1 = Y.
- REQ-012 Port step_dir, output, 1: 0 = increment (sample positive), 1 = decrement (sample negative).
- REQ-013 Port step_ready, input, 1: the ball module accepts the offered move.
- REQ-014 Port active, output, 2: bit0/bit1 high while the X/Y magnitude exceeds DEADZONE.

Function
- REQ-015 Sample capture: on accel_valid, accel_x and accel_y SHALL be registered; the axis timers SHALL use the registered values from the next cycle.
- REQ-016 Magnitude: mag = |sample| (8 bit); -256 SHALL saturate to 255.
- REQ-017 Prescaler: a tick SHALL pulse for one cycle every TICK_DIV cycles, free-running from reset.
- REQ-018 Period: period = PERIOD_MAX - (mag - DEADZONE), clipped to no less than PERIOD_MIN.
- REQ-019 Axis timer, when enable=1 and mag > DEADZONE:
  - the counter SHALL increment on each tick;
  - when the counter reaches period, it SHALL clear and set the axis pending flag;
  - the direction SHALL be latched from the sample sign at that moment.
- REQ-020 If pending is already set when the period is reached, the counter SHALL hold at period; requests SHALL NOT queue beyond one per axis.
- REQ-021 mag <= DEADZONE or enable=0: the counter SHALL clear and no new pending is set; an existing pending SHALL be kept and delivered.
- REQ-022 Arbiter: step_valid = pending_x OR pending_y.
  - With one pending, that axis SHALL be offered.
  - With both pending, the axis not granted last SHALL be offered (round-robin).
- REQ-023 Handshake: once step_valid is high, step_valid, step_axis and step_dir SHALL stay stable until step_ready is sampled high.
- REQ-024 Transfer: a transfer occurs when step_valid and step_ready are both high.
  - The granted pending flag SHALL clear in that cycle and the last-granted pointer SHALL update.
  - At most one transfer SHALL occur per cycle.
- REQ-025 If a transfer and a new pending set hit the same axis in the same cycle, the set SHALL win and pending stays high.
- REQ-026 The arbiter SHALL be implemented as FSM states IDLE, OFFER_X and OFFER_Y.
  - IDLE -> OFFER_x when that axis is pending, with priority per REQ-022.
  - OFFER -> IDLE or the other OFFER on transfer.
  - Step_valid latency SHALL be one cycle after pending sets.

Reset
- REQ-027 Reset SHALL asynchronously clear all of the following: counters, prescaler, pending flags, sample registers, FSM (to IDLE).
- REQ-028 On reset, step_valid, step_axis, step_dir and active SHALL all be 0.
- REQ-029 On reset, the last-granted pointer SHALL be Y, so X wins the first tie.
- REQ-030 Reset asserted mid-offer SHALL drop the request with no transfer.

Configuration
- REQ-031 Macro TILT_SMOOTH_EN defined: each captured sample SHALL be the arithmetic-shift average (prev+new)>>>1 of the last two accel_valid samples, computed in 10-bit.
- REQ-032 Macro TILT_SMOOTH_EN undefined: the raw sample SHALL be used.

Structure
- REQ-033 Package tilt_pkg SHALL hold the following: the axis encoding, the direction encoding, the FSM state typedef, and the default DEADZONE/PERIOD constants.
- REQ-034 Sub-module tilt_axis_timer SHALL be instantiated twice and contain the following: magnitude, period, counter, pending and direction logic.
- REQ-035 The arbiter and prescaler SHALL live in the top level.

Verification (SIMULATE=1, defaults, step_ready=1 unless stated)
- REQ-036 accel_x=+100, accel_y=0, enable=1 -> period 171; first step_valid with axis=0, dir=0 appears 171 ticks after capture, then repeats every 171 ticks.
- REQ-037 accel_x=+10, accel_y=-16 -> no step_valid over 1000 ticks; active=00.
- REQ-038 accel_x=-256 -> mag 255, period 16; steps with axis=0, dir=1 every 16 ticks.
- REQ-039 accel_x=accel_y=+255 -> both pending on the same tick; X transfers in the first cycle and Y in the next cycle.
- REQ-040 step_ready held low for 50 ticks with accel_x=-256:
  - payload stays stable throughout;
  - on release, exactly one X transfer occurs;
  - the counter holds at period.
- REQ-041 reset pulsed while step_valid=1 -> all outputs are 0 within the same cycle; the first step after release arrives a full period later.

Source files
------------

// File: rtl/tilt_pkg.sv
`default_nettype none
// ============================================================================
// Module : tilt_pkg
// Brief  : Shared encodings, arbiter state codes and default constants for
//          the tilt step scheduler.
// Rev    : 1.0  initial release
// ============================================================================
package tilt_pkg;

  typedef enum logic {AXIS_X = 1'b0, AXIS_Y = 1'b1} axis_e;
  typedef enum logic {DIR_INC = 1'b0, DIR_DEC = 1'b1} dir_e;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE    = 2'd0;
  localparam state_t ST_OFFER_X = 2'd1;
  localparam state_t ST_OFFER_Y = 2'd2;

  localparam int DEADZONE_DEF   = 16;
  localparam int PERIOD_MAX_DEF = 255;
  localparam int PERIOD_MIN_DEF = 8;

  // Stronger tilt gives a shorter period, floored at pmin.
  function automatic logic [7:0] calc_period(input logic [7:0] mag, input int dz,
                                             input int pmax, input int pmin);
    int p;
    p = pmax - (int'(mag) - dz);
    if (p < pmin) p = pmin;
    if (p > 255) p = 255;
    return p[7:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/tilt_step_sched_if.sv
`default_nettype none
// ============================================================================
// Module : tilt_step_sched_if
// Brief  : Ball-move request handshake between scheduler and ball module.
// Rev    : 1.0  initial release
// ============================================================================
interface tilt_step_sched_if;
  logic step_valid;
  logic step_axis;
  logic step_dir;
  logic step_ready;

  modport master (output step_valid, output step_axis, output step_dir, input step_ready);
  modport slave  (input step_valid, input step_axis, input step_dir, output step_ready);
endinterface
`default_nettype wire

// File: rtl/tilt_axis_timer.sv
`default_nettype none
// ============================================================================
// Module : tilt_axis_timer
// Brief  : Per-axis magnitude, period, tick counter, pending flag and
//          latched direction.
// Rev    : 1.0  initial release
// ============================================================================
module tilt_axis_timer
  import tilt_pkg::*;
#(
  parameter int DEADZONE   = DEADZONE_DEF,
  parameter int PERIOD_MAX = PERIOD_MAX_DEF,
  parameter int PERIOD_MIN = PERIOD_MIN_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [8:0] sample,
  input  logic       enable,
  input  logic       tick,
  input  logic       grant,
  output logic       pending,
  output logic       dir,
  output logic       active
);

  logic [8:0] neg;
  logic [7:0] mag;
  logic [7:0] period;
  logic [7:0] count;
  logic [8:0] next_cnt;
  logic       run;
  logic       reach;
  logic       fire;

  always_comb begin
    neg = 9'd0 - sample;
    if (!sample[8])  mag = sample[7:0];
    else if (neg[8]) mag = 8'hFF;   // -256 has no 8-bit magnitude
    else             mag = neg[7:0];
  end

  assign period   = calc_period(mag, DEADZONE, PERIOD_MAX, PERIOD_MIN);
  assign active   = int'(mag) > DEADZONE;
  assign run      = enable && active;
  assign next_cnt = {1'b0, count} + 9'd1;
  assign reach    = tick && (next_cnt >= {1'b0, period});
  // A transfer in the same cycle frees the slot, so the new request wins.
  assign fire     = run && reach && (!pending || grant);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count   <= 8'd0;
      pending <= 1'b0;
      dir     <= 1'b0;
    end else begin
      if (!run)
        count <= 8'd0;
      else if (reach)
        count <= fire ? 8'd0 : period;
      else if (tick)
        count <= next_cnt[7:0];

      if (fire) begin
        pending <= 1'b1;
        dir     <= sample[8] ? DIR_DEC : DIR_INC;
      end else if (grant) begin
        pending <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/tilt_step_sched.sv
`default_nettype none
// ============================================================================
// Module : tilt_step_sched
// Brief  : Tilt-driven ball step scheduler: prescaler, two axis timers and a
//          round-robin request arbiter. TILT_SMOOTH_EN averages samples.
// Rev    : 1.0  initial release
// ============================================================================
module tilt_step_sched
  import tilt_pkg::*;
#(
  parameter int TICK_DIV   = 100000,
  parameter int SIMULATE   = 0,
  parameter int DEADZONE   = DEADZONE_DEF,
  parameter int PERIOD_MAX = PERIOD_MAX_DEF,
  parameter int PERIOD_MIN = PERIOD_MIN_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [8:0] accel_x,
  input  logic [8:0] accel_y,
  input  logic       accel_valid,
  input  logic       enable,
  output logic [1:0] active,
  tilt_step_sched_if.master step
);

  localparam int TDIV = (SIMULATE != 0) ? 4 : TICK_DIV;
  localparam int PW   = (TDIV > 1) ? $clog2(TDIV) : 1;

  logic [PW-1:0] pre_cnt;
  logic          tick;
  logic [8:0]    sample_x;
  logic [8:0]    sample_y;
  logic          pend_x, pend_y;
  logic          dir_x, dir_y;
  logic          grant_x, grant_y;
  state_t        state, state_nx;
  axis_e         last;

  assign tick = (pre_cnt == PW'(TDIV - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset)     pre_cnt <= '0;
    else if (tick) pre_cnt <= '0;
    else           pre_cnt <= pre_cnt + 1'b1;
  end

`ifdef TILT_SMOOTH_EN
  logic [8:0] prev_x, prev_y;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_x   <= 9'd0;
      prev_y   <= 9'd0;
      sample_x <= 9'd0;
      sample_y <= 9'd0;
    end else if (accel_valid) begin
      prev_x   <= accel_x;
      prev_y   <= accel_y;
      sample_x <= 9'(($signed({accel_x[8], accel_x}) + $signed({prev_x[8], prev_x})) >>> 1);
      sample_y <= 9'(($signed({accel_y[8], accel_y}) + $signed({prev_y[8], prev_y})) >>> 1);
    end
  end
`else
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sample_x <= 9'd0;
      sample_y <= 9'd0;
    end else if (accel_valid) begin
      sample_x <= accel_x;
      sample_y <= accel_y;
    end
  end
`endif

  tilt_axis_timer #(.DEADZONE(DEADZONE), .PERIOD_MAX(PERIOD_MAX), .PERIOD_MIN(PERIOD_MIN))
  u_timer_x (
    .clk(clk), .reset(reset), .sample(sample_x), .enable(enable), .tick(tick),
    .grant(grant_x), .pending(pend_x), .dir(dir_x), .active(active[0])
  );

  tilt_axis_timer #(.DEADZONE(DEADZONE), .PERIOD_MAX(PERIOD_MAX), .PERIOD_MIN(PERIOD_MIN))
  u_timer_y (
    .clk(clk), .reset(reset), .sample(sample_y), .enable(enable), .tick(tick),
    .grant(grant_y), .pending(pend_y), .dir(dir_y), .active(active[1])
  );

  assign grant_x = (state == ST_OFFER_X) && step.step_ready;
  assign grant_y = (state == ST_OFFER_Y) && step.step_ready;

  // An offer is only left on a transfer, keeping the payload stable.
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: begin
        if (pend_x && (!pend_y || last == AXIS_Y)) state_nx = ST_OFFER_X;
        else if (pend_y)                          state_nx = ST_OFFER_Y;
      end
      ST_OFFER_X: if (step.step_ready) state_nx = pend_y ? ST_OFFER_Y : ST_IDLE;
      ST_OFFER_Y: if (step.step_ready) state_nx = pend_x ? ST_OFFER_X : ST_IDLE;
      default:    state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      last  <= AXIS_Y;
    end else begin
      state <= state_nx;
      if (grant_x)      last <= AXIS_X;
      else if (grant_y) last <= AXIS_Y;
    end
  end

  assign step.step_valid = (state != ST_IDLE);
  assign step.step_axis  = (state == ST_OFFER_Y);
  assign step.step_dir   = (state == ST_OFFER_X) ? dir_x :
                           (state == ST_OFFER_Y) ? dir_y : 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_tilt_step_sched.sv
`default_nettype none
// ============================================================================
// Module : tb_tilt_step_sched
// Brief  : Self-checking bench for tilt_step_sched (SIMULATE=1, defaults).
// Rev    : 1.0  initial release
// ============================================================================
module tb_tilt_step_sched;

  localparam int TD   = 4;
  localparam int DZ   = 16;
  localparam int PMAX = 255;
  localparam int PMIN = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [8:0] accel_x = 9'd0;
  logic [8:0] accel_y = 9'd0;
  logic       accel_valid = 1'b0;
  logic       enable = 1'b1;
  logic [1:0] active;
  int         checks = 0;
  int         passed = 0;
  int         xfers = 0;

  tilt_step_sched_if step_bus ();

  tilt_step_sched #(.TICK_DIV(100000), .SIMULATE(1), .DEADZONE(DZ),
                    .PERIOD_MAX(PMAX), .PERIOD_MIN(PMIN)) dut (
    .clk(clk), .reset(reset), .accel_x(accel_x), .accel_y(accel_y),
    .accel_valid(accel_valid), .enable(enable), .active(active), .step(step_bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (step_bus.step_valid && step_bus.step_ready) xfers++;

  function automatic int exp_mag(input int v);
    int m;
    m = (v < 0) ? -v : v;
    return (m > 255) ? 255 : m;
  endfunction

  function automatic int exp_period(input int m);
    int p;
    p = PMAX - (m - DZ);
    return (p < PMIN) ? PMIN : p;
  endfunction

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset();
    reset = 1'b1; accel_valid = 1'b0; accel_x = 9'd0; accel_y = 9'd0;
    cyc(2);
    reset = 1'b0;
    cyc(1);
  endtask

  task automatic capture(input int xv, input int yv);
    accel_x = 9'(xv); accel_y = 9'(yv); accel_valid = 1'b1;
    cyc(1);
    accel_valid = 1'b0;
  endtask

  task automatic wait_valid(input int limit, output int n);
    n = 0;
    while (step_bus.step_valid !== 1'b1 && n < limit) begin cyc(1); n++; end
  endtask

  task automatic test_reset();
    reset = 1'b1; step_bus.step_ready = 1'b1;
    cyc(3);
    checks++; if (step_bus.step_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", step_bus.step_valid); else passed++;
    checks++; if (step_bus.step_axis !== 1'b0) $display("FAIL reset_axis got %b want 0", step_bus.step_axis); else passed++;
    checks++; if (step_bus.step_dir !== 1'b0) $display("FAIL reset_dir got %b want 0", step_bus.step_dir); else passed++;
    checks++; if (active !== 2'b00) $display("FAIL reset_active got %b want 00", active); else passed++;
    reset = 1'b0;
    cyc(1);
  endtask

  // Single tilted axis with ready held high: latency, payload and repeat rate.
  task automatic test_stream(input int xv, input int yv, input logic ax, input string name);
    int p, n;
    logic exp_dir;
    logic [1:0] exp_act;
    p = exp_period(exp_mag(ax ? yv : xv));
    exp_dir = ((ax ? yv : xv) < 0);
    exp_act = {logic'(exp_mag(yv) > DZ), logic'(exp_mag(xv) > DZ)};
    do_reset();
    step_bus.step_ready = 1'b1; enable = 1'b1;
    capture(xv, yv);
    wait_valid(4 * p + 10, n);
    checks++;
    if (n < TD * p - 2 || n > TD * p + 1)
      $display("FAIL %s_first_latency got %0d want %0d..%0d cycles", name, n, TD * p - 2, TD * p + 1);
    else passed++;
    checks++; if (step_bus.step_axis !== ax) $display("FAIL %s_axis got %b want %b", name, step_bus.step_axis, ax); else passed++;
    checks++; if (step_bus.step_dir !== exp_dir) $display("FAIL %s_dir got %b want %b", name, step_bus.step_dir, exp_dir); else passed++;
    checks++; if (active !== exp_act) $display("FAIL %s_active got %b want %b", name, active, exp_act); else passed++;
    for (int k = 0; k < 2; k++) begin
      cyc(1);
      wait_valid(TD * p + 10, n);
      checks++;
      if (n != TD * p - 1) $display("FAIL %s_interval got %0d want %0d cycles", name, n + 1, TD * p); else passed++;
    end
  endtask

  task automatic test_random();
    int m, v;
    logic ax;
    for (int i = 0; i < 6; i++) begin
      m  = $urandom_range(17, 256);
      v  = ($urandom_range(0, 1) == 1 || m == 256) ? -m : m;
      ax = logic'($urandom_range(0, 1));
      if (ax) test_stream(0, v, 1'b1, "random_y");
      else    test_stream(v, 0, 1'b0, "random_x");
    end
  endtask

  task automatic test_deadzone();
    int seen;
    int xv, yv;
    for (int i = 0; i < 4; i++) begin
      xv = (i == 0) ? 10  : int'($urandom_range(0, 32)) - 16;
      yv = (i == 0) ? -16 : int'($urandom_range(0, 32)) - 16;
      do_reset();
      step_bus.step_ready = 1'b1; enable = 1'b1;
      capture(xv, yv);
      seen = 0;
      for (int c = 0; c < ((i == 0) ? 1000 * TD : 400); c++) begin
        cyc(1);
        if (step_bus.step_valid === 1'b1) seen++;
      end
      checks++; if (seen != 0) $display("FAIL deadzone_steps x=%0d y=%0d got %0d want 0", xv, yv, seen); else passed++;
      checks++; if (active !== 2'b00) $display("FAIL deadzone_active got %b want 00", active); else passed++;
    end
  endtask

  task automatic test_both();
    int n;
    do_reset();
    step_bus.step_ready = 1'b1; enable = 1'b1;
    capture(255, 255);
    wait_valid(100, n);
    xfers = 0;
    checks++; if (step_bus.step_valid !== 1'b1 || step_bus.step_axis !== 1'b0)
      $display("FAIL both_first got v=%b a=%b want v=1 a=0", step_bus.step_valid, step_bus.step_axis); else passed++;
    cyc(1);
    checks++; if (step_bus.step_valid !== 1'b1 || step_bus.step_axis !== 1'b1)
      $display("FAIL both_second got v=%b a=%b want v=1 a=1", step_bus.step_valid, step_bus.step_axis); else passed++;
    cyc(1);
    checks++; if (step_bus.step_valid !== 1'b0) $display("FAIL both_drain got %b want 0", step_bus.step_valid); else passed++;
    checks++; if (xfers != 2) $display("FAIL both_xfers got %0d want 2", xfers); else passed++;
  endtask

  task automatic test_backpressure();
    int n, bad;
    do_reset();
    step_bus.step_ready = 1'b0; enable = 1'b1;
    capture(-256, 0);
    wait_valid(100, n);
    bad = 0;
    for (int c = 0; c < 50 * TD; c++) begin
      cyc(1);
      if (step_bus.step_valid !== 1'b1 || step_bus.step_axis !== 1'b0 || step_bus.step_dir !== 1'b1) bad++;
    end
    checks++; if (bad != 0) $display("FAIL hold_stable got %0d unstable cycles want 0", bad); else passed++;
    checks++; if (dut.u_timer_x.count !== 8'd16) $display("FAIL hold_counter got %0d want 16", dut.u_timer_x.count); else passed++;
    xfers = 0;
    step_bus.step_ready = 1'b1;
    cyc(1);
    step_bus.step_ready = 1'b0;
    checks++; if (step_bus.step_valid !== 1'b0) $display("FAIL release_drop got %b want 0", step_bus.step_valid); else passed++;
    cyc(8);
    checks++; if (xfers != 1) $display("FAIL release_xfers got %0d want 1", xfers); else passed++;
  endtask

  task automatic test_enable();
    int n, seen;
    do_reset();
    step_bus.step_ready = 1'b1; enable = 1'b0;
    capture(-256, 0);
    seen = 0;
    for (int c = 0; c < 200; c++) begin cyc(1); if (step_bus.step_valid === 1'b1) seen++; end
    checks++; if (seen != 0) $display("FAIL disabled_steps got %0d want 0", seen); else passed++;
    checks++; if (active !== 2'b01) $display("FAIL disabled_active got %b want 01", active); else passed++;
    enable = 1'b1;
    wait_valid(80, n);
    checks++; if (step_bus.step_valid !== 1'b1) $display("FAIL enable_resume got timeout after %0d cycles", n); else passed++;
  endtask

  task automatic test_reset_mid_offer();
    int n;
    do_reset();
    step_bus.step_ready = 1'b0; enable = 1'b1;
    capture(-256, 0);
    wait_valid(100, n);
    reset = 1'b1;
    #1;
    checks++; if ({step_bus.step_valid, step_bus.step_axis, step_bus.step_dir, active} !== 5'd0)
      $display("FAIL midreset_outputs got %b want 00000",
               {step_bus.step_valid, step_bus.step_axis, step_bus.step_dir, active}); else passed++;
    cyc(2);
    reset = 1'b0;
    step_bus.step_ready = 1'b1;
    cyc(1);
    capture(-256, 0);
    wait_valid(100, n);
    checks++; if (n < TD * 16 - 2 || n > TD * 16 + 1)
      $display("FAIL midreset_latency got %0d want %0d..%0d", n, TD * 16 - 2, TD * 16 + 1); else passed++;
  endtask

  initial begin
    step_bus.step_ready = 1'b1;
    test_reset();
    test_stream(100, 0, 1'b0, "x_plus100");
    test_stream(-256, 0, 1'b0, "x_minus256");
    test_random();
    test_deadzone();
    test_both();
    test_backpressure();
    test_enable();
    test_reset_mid_offer();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
`default_nettype wire
